mux16_stream_arbiter: RTL and testbench



---
 rtl/mux16_stream_arbiter_if.sv | 33 +++
 rtl/mux16_stream_arbiter.sv | 81 ++++++++
 tb/tb_mux16_stream_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mux16_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux16_stream_arbiter_if
// Brief    : Bundles the two producer streams and the merged consumer stream.
// Revision : 1.0 - initial release
// ============================================================================
interface mux16_stream_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_ready;

    // Environment side: producers on a/b and the consumer on out.
    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_sel
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_sel
    );
endinterface
`default_nettype wire

// File: rtl/mux16_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux16_stream_arbiter
// Brief    : Two-input valid/ready merge onto one registered output stream;
//            out_sel tags each word with its source (0 = a, 1 = b).
//            Build option MUX16_ARB_FIXED_PRIO_EN: a always wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module mux16_stream_arbiter #(
    parameter int WIDTH = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    mux16_stream_arbiter_if.slave   bus
);

    localparam logic c_SEL_A = 1'b0;
    localparam logic c_SEL_B = 1'b1;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_sel;

    logic             w_load;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_xfer;
    logic             w_grant_id;
    logic [WIDTH-1:0] w_grant_data;

    // Output register can accept a word when empty or draining this cycle.
    assign w_load = !r_out_valid || bus.out_ready;

`ifdef MUX16_ARB_FIXED_PRIO_EN
    assign w_grant_a = bus.a_valid;
    assign w_grant_b = bus.b_valid && !bus.a_valid;
`else
    // last_grant remembers the most recent transferred source; a tie goes
    // to the other channel. Reset value of b lets a win the first tie.
    logic r_last_grant;

    assign w_grant_a = bus.a_valid && (!bus.b_valid || (r_last_grant == c_SEL_B));
    assign w_grant_b = bus.b_valid && (!bus.a_valid || (r_last_grant == c_SEL_A));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_SEL_B;
        end else if (w_xfer) begin
            r_last_grant <= w_grant_id;
        end
    end
`endif

    assign w_xfer       = w_load && (w_grant_a || w_grant_b);
    assign w_grant_id   = w_grant_b ? c_SEL_B : c_SEL_A;
    assign w_grant_data = w_grant_b ? bus.b_data : bus.a_data;

    // Readies are masked while reset is held so nothing is accepted then.
    assign bus.a_ready = rst_n && w_load && w_grant_a;
    assign bus.b_ready = rst_n && w_load && w_grant_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= c_SEL_A;
        end else if (w_load) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_grant_data;
                r_out_sel  <= w_grant_id;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux16_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux16_stream_arbiter
// Brief    : Directed vector-table bench for mux16_stream_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux16_stream_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    mux16_stream_arbiter_if #(.WIDTH(16)) bus ();

    mux16_stream_arbiter #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [15:0] ad;
        logic        bv;
        logic [15:0] bd;
        logic        ordy;
        logic        exp_ar;
        logic        exp_br;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic        exp_sel;
    } vec_t;

    localparam int c_NVEC = 14;
    vec_t vecs [c_NVEC];

    function automatic vec_t mk(input logic av, input logic [15:0] ad,
                                input logic bv, input logic [15:0] bd,
                                input logic ordy, input logic ar, input logic br,
                                input logic ov, input logic [15:0] od,
                                input logic sel);
        vec_t v;
        v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
        v.exp_ar = ar; v.exp_br = br; v.exp_ov = ov; v.exp_od = od; v.exp_sel = sel;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [15:0] ad,
                         input logic bv, input logic [15:0] bd, input logic ordy);
        bus.a_valid   = av;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_data    = bd;
        bus.out_ready = ordy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // idx: inputs (av ad bv bd ordy) | readies | registered outputs after edge
        vecs[0]  = mk(1, 16'h00A1, 1, 16'h00B1, 1, 1, 0, 1, 16'h00A1, 0);
        vecs[1]  = mk(0, 16'h0000, 1, 16'hBEEF, 1, 0, 1, 1, 16'hBEEF, 1);
        vecs[2]  = mk(1, 16'h000A, 1, 16'h000B, 1, 1, 0, 1, 16'h000A, 0);
`ifdef MUX16_ARB_FIXED_PRIO_EN
        vecs[3]  = mk(1, 16'h000A, 1, 16'h000B, 1, 1, 0, 1, 16'h000A, 0);
        vecs[4]  = mk(1, 16'h000A, 1, 16'h000B, 1, 1, 0, 1, 16'h000A, 0);
        vecs[5]  = mk(1, 16'h000A, 1, 16'h000B, 1, 1, 0, 1, 16'h000A, 0);
        vecs[6]  = mk(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 16'h000A, 0);
`else
        vecs[3]  = mk(1, 16'h000A, 1, 16'h000B, 1, 0, 1, 1, 16'h000B, 1);
        vecs[4]  = mk(1, 16'h000A, 1, 16'h000B, 1, 1, 0, 1, 16'h000A, 0);
        vecs[5]  = mk(1, 16'h000A, 1, 16'h000B, 1, 0, 1, 1, 16'h000B, 1);
        vecs[6]  = mk(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 16'h000B, 1);
`endif
        vecs[7]  = mk(1, 16'h1234, 0, 16'h0000, 1, 1, 0, 1, 16'h1234, 0);
        vecs[8]  = mk(1, 16'h5555, 1, 16'h6666, 0, 0, 0, 1, 16'h1234, 0);
        vecs[9]  = mk(1, 16'h5555, 1, 16'h6666, 0, 0, 0, 1, 16'h1234, 0);
        vecs[10] = mk(1, 16'h5555, 1, 16'h6666, 0, 0, 0, 1, 16'h1234, 0);
`ifdef MUX16_ARB_FIXED_PRIO_EN
        vecs[11] = mk(1, 16'h5555, 1, 16'h6666, 1, 1, 0, 1, 16'h5555, 0);
        vecs[12] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 16'h5555, 0);
`else
        vecs[11] = mk(1, 16'h5555, 1, 16'h6666, 1, 0, 1, 1, 16'h6666, 1);
        vecs[12] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 16'h6666, 1);
`endif
        vecs[13] = mk(1, 16'h0F0F, 0, 16'h0000, 1, 1, 0, 1, 16'h0F0F, 0);

        // Reset held with both producers valid.
        drive(1, 16'hFFFF, 1, 16'hEEEE, 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_out_sel",   32'(bus.out_sel),   32'h0);
        check("rst_a_ready",   32'(bus.a_ready),   32'h0);
        check("rst_b_ready",   32'(bus.b_ready),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < c_NVEC; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy);
            #1;
            check($sformatf("v%0d_a_ready", i), 32'(bus.a_ready), 32'(vecs[i].exp_ar));
            check($sformatf("v%0d_b_ready", i), 32'(bus.b_ready), 32'(vecs[i].exp_br));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d_out_data", i),  32'(bus.out_data),  32'(vecs[i].exp_od));
            check($sformatf("v%0d_out_sel", i),   32'(bus.out_sel),   32'(vecs[i].exp_sel));
        end

        // Async reset between edges while a word is held; a was granted last.
        drive(1, 16'hAAAA, 1, 16'hBBBB, 0);
        #1;
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst_out_data",  32'(bus.out_data),  32'h0);
        check("async_rst_a_ready",   32'(bus.a_ready),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 16'hAAAA, 1, 16'hBBBB, 1);
        #1;
        check("post_rst_a_ready", 32'(bus.a_ready), 32'h1);
        check("post_rst_b_ready", 32'(bus.b_ready), 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_out_sel",  32'(bus.out_sel),  32'h0);
        check("post_rst_out_data", 32'(bus.out_data), 32'hAAAA);

        // Sustained tie: count b grants over eight full-throughput cycles.
        begin
            int b_cnt;
            b_cnt = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                b_cnt += int'(bus.b_ready);
            end
`ifdef MUX16_ARB_FIXED_PRIO_EN
            check("sustained_b_grants", 32'(b_cnt), 32'd0);
`else
            check("sustained_b_grants", 32'(b_cnt), 32'd4);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
